fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_pkg.sv | 13 +
 rtl/fetch_pc_ras.sv | 65 ++++++
 rtl/fetch_pc_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch PC unit: state encoding, PC step and default trap vector.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INC            = 4;
  localparam logic [31:0] DEFAULT_TRAP_ADDR = 32'h0000_0100;

endpackage

// File: rtl/fetch_pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module fetch_pc_ras
  import fetch_pc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-1:0] push_data_i,
  output logic [ADDR_WIDTH-1:0] top_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      w_top_idx;
  logic                  w_pop;

  // r_ptr is the next write slot, so the top lives one below it (wrapping).
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign top_o     = r_mem[w_top_idx];
  assign empty_o   = (r_count == {CNT_W{1'b0}});
  assign full_o    = (r_count == FULL_CNT);
  assign w_pop     = pop_i & ~empty_o;

  // Stack storage, pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {ADDR_WIDTH{1'b0}};
      end
      r_ptr   <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({push_i, w_pop})
        2'b11: begin
          r_mem[w_top_idx] <= push_data_i;
        end
        2'b10: begin
          r_mem[r_ptr] <= push_data_i;
          r_ptr        <= r_ptr + PTR_W'(1);
          r_count      <= full_o ? r_count : r_count + CNT_W'(1);
        end
        2'b01: begin
          r_ptr   <= w_top_idx;
          r_count <= r_count - CNT_W'(1);
        end
        default: begin
          r_ptr   <= r_ptr;
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program-counter sequencer with trap, redirect and halt handling.
// Optional return-address stack is built when FETCH_PC_RAS_EN is defined.
module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = {ADDR_WIDTH{1'b0}},
  parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR  = ADDR_WIDTH'(DEFAULT_TRAP_ADDR),
  parameter int unsigned           RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fetch_req_o,
  input  logic                  fetch_ack_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic                  redirect_i,
  input  logic                  redirect_abs_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  input  logic                  call_i,
  input  logic                  ret_i,
  input  logic                  trap_i,
  input  logic                  halt_i,
  output logic                  misalign_o
);

  localparam logic [ADDR_WIDTH-1:0] BIT0_MASK = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  r_fetch_req;
  logic                  r_misalign;
  logic                  w_misalign_nxt;
  logic                  w_accept_redir;
  logic                  w_use_ras;
  logic [ADDR_WIDTH-1:0] w_ras_top;

  assign w_pc_inc       = r_pc + ADDR_WIDTH'(PC_INC);
  assign w_accept_redir = redirect_i & ~trap_i & ((r_state == ST_RUN) | (r_state == ST_HALT));

`ifdef FETCH_PC_RAS_EN
  logic w_ras_empty;
  logic w_unused_ras_full;

  fetch_pc_ras #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_accept_redir & call_i),
    .pop_i       (w_accept_redir & ret_i),
    .push_data_i (w_pc_inc),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty),
    .full_o      (w_unused_ras_full)
  );

  assign w_use_ras = ret_i & ~w_ras_empty;
`else
  logic w_unused_ras_ports;

  assign w_unused_ras_ports = call_i ^ ret_i;
  assign w_use_ras          = 1'b0;
  assign w_ras_top          = {ADDR_WIDTH{1'b0}};
`endif

  // Redirect target selection: return address, absolute or pc-relative.
  always_comb begin
    w_target = r_pc + target_i;
    if (w_use_ras) begin
      w_target = w_ras_top & BIT0_MASK;
    end else if (redirect_abs_i) begin
      w_target = target_i & BIT0_MASK;
    end else begin
      w_target = r_pc + target_i;
    end
  end

  // Next state / next PC: trap > redirect > acknowledged increment > hold.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_misalign_nxt = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN, ST_HALT: begin
        if (trap_i) begin
          w_pc_nxt    = TRAP_ADDR;
          w_state_nxt = ST_RUN;
        end else if (redirect_i) begin
          if (w_target[1]) begin
            w_pc_nxt       = TRAP_ADDR;
            w_misalign_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_target;
          end
        end else begin
          if (r_fetch_req && fetch_ack_i) begin
            w_pc_nxt = w_pc_inc;
          end else begin
            w_pc_nxt = r_pc;
          end
          if ((r_state == ST_RUN) && halt_i) begin
            w_state_nxt = ST_HALT;
          end else if ((r_state == ST_HALT) && !halt_i) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = r_state;
          end
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_pc_nxt    = RESET_ADDR;
      end
    endcase
  end

  // State, PC and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_ADDR;
      r_fetch_req <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_fetch_req <= (w_state_nxt == ST_RUN);
      r_misalign  <= w_misalign_nxt;
    end
  end

  assign fetch_req_o = r_fetch_req;
  assign pc_o        = r_pc;
  assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; RAS vectors run when FETCH_PC_RAS_EN is defined.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_req_o;
  logic        fetch_ack_i;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic        redirect_abs_i;
  logic [31:0] target_i;
  logic        call_i;
  logic        ret_i;
  logic        trap_i;
  logic        halt_i;
  logic        misalign_o;

  int checks   = 0;
  int failures = 0;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_req_o    (fetch_req_o),
    .fetch_ack_i    (fetch_ack_i),
    .pc_o           (pc_o),
    .redirect_i     (redirect_i),
    .redirect_abs_i (redirect_abs_i),
    .target_i       (target_i),
    .call_i         (call_i),
    .ret_i          (ret_i),
    .trap_i         (trap_i),
    .halt_i         (halt_i),
    .misalign_o     (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic abs, input logic [31:0] tgt, input logic call, input logic ret);
    redirect_i     = 1'b1;
    redirect_abs_i = abs;
    target_i       = tgt;
    call_i         = call;
    ret_i          = ret;
    step();
    redirect_i     = 1'b0;
    redirect_abs_i = 1'b0;
    target_i       = 32'h0;
    call_i         = 1'b0;
    ret_i          = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_ack_i    = 1'b1;
    redirect_i     = 1'b0;
    redirect_abs_i = 1'b0;
    target_i       = 32'h0;
    call_i         = 1'b0;
    ret_i          = 1'b0;
    trap_i         = 1'b0;
    halt_i         = 1'b0;

    // Reset and boot sequence
    step();
    step();
    check_val("rst_pc", pc_o, 32'h0);
    check_val("rst_req", {31'h0, fetch_req_o}, 32'h0);
    check_val("rst_mis", {31'h0, misalign_o}, 32'h0);
    rst_n = 1'b1;
    #2;
    check_val("boot_req", {31'h0, fetch_req_o}, 32'h0);
    step();
    check_val("run_req", {31'h0, fetch_req_o}, 32'h1);
    check_val("seq_pc0", pc_o, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_val("seq_pc", pc_o, 32'(i * 4));
    end

    // Stall at 0x10
    fetch_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_hold", pc_o, 32'h10);
    end
    fetch_ack_i = 1'b1;
    step();
    check_val("stall_resume", pc_o, 32'h14);

    // Redirects
    fetch_ack_i = 1'b0;
    redir(1'b1, 32'h20, 1'b0, 1'b0);
    check_val("redir_setup", pc_o, 32'h20);
    redir(1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0);
    check_val("redir_rel_neg", pc_o, 32'h18);
    redir(1'b1, 32'h41, 1'b0, 1'b0);
    check_val("redir_abs_bit0", pc_o, 32'h40);
    check_val("redir_no_mis", {31'h0, misalign_o}, 32'h0);
    redir(1'b1, 32'h42, 1'b0, 1'b0);
    check_val("misalign_pc", pc_o, 32'h100);
    check_val("misalign_pulse", {31'h0, misalign_o}, 32'h1);
    step();
    check_val("misalign_drop", {31'h0, misalign_o}, 32'h0);
    check_val("misalign_hold", pc_o, 32'h100);

    // Priority: trap beats redirect
    redir(1'b1, 32'h30, 1'b0, 1'b0);
    check_val("prio_setup", pc_o, 32'h30);
    trap_i = 1'b1;
    redir(1'b1, 32'h200, 1'b0, 1'b0);
    trap_i = 1'b0;
    check_val("prio_trap", pc_o, 32'h100);

    // Halt: no fetch, PC held, redirect still taken
    halt_i = 1'b1;
    step();
    check_val("halt_req", {31'h0, fetch_req_o}, 32'h0);
    fetch_ack_i = 1'b1;
    step();
    check_val("halt_pc_hold", pc_o, 32'h100);
    redir(1'b1, 32'h60, 1'b0, 1'b0);
    check_val("halt_redir_pc", pc_o, 32'h60);
    check_val("halt_redir_req", {31'h0, fetch_req_o}, 32'h0);
    halt_i = 1'b0;
    step();
    check_val("unhalt_req", {31'h0, fetch_req_o}, 32'h1);
    check_val("unhalt_pc", pc_o, 32'h60);
    step();
    check_val("unhalt_inc", pc_o, 32'h64);

    // Wrap at the top of the address space
    fetch_ack_i = 1'b0;
    redir(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check_val("wrap_setup", pc_o, 32'hFFFF_FFFC);
    fetch_ack_i = 1'b1;
    step();
    check_val("wrap_pc", pc_o, 32'h0);

    // call/ret without redirect have no effect
    fetch_ack_i = 1'b0;
    call_i      = 1'b1;
    ret_i       = 1'b1;
    step();
    call_i      = 1'b0;
    ret_i       = 1'b0;
    check_val("callret_idle", pc_o, 32'h0);

    // Call then return
    redir(1'b1, 32'h80, 1'b0, 1'b0);
    redir(1'b1, 32'h200, 1'b1, 1'b0);
    check_val("call_pc", pc_o, 32'h200);
    redir(1'b1, 32'h0, 1'b0, 1'b1);
`ifdef FETCH_PC_RAS_EN
    check_val("ret_pc", pc_o, 32'h84);

    // Overflow: five calls into a four-deep stack
    redir(1'b1, 32'h1000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      redir(1'b1, 32'((i + 2) * 32'h1000), 1'b1, 1'b0);
      check_val("deep_call", pc_o, 32'((i + 2) * 32'h1000));
    end
    for (int i = 0; i < 4; i++) begin
      redir(1'b1, 32'h0, 1'b0, 1'b1);
      check_val("deep_ret", pc_o, 32'((5 - i) * 32'h1000 + 4));
    end
    redir(1'b1, 32'h700, 1'b0, 1'b1);
    check_val("deep_ret_empty", pc_o, 32'h700);
`else
    check_val("ret_ignored", pc_o, 32'h0);
`endif

    // Reset asserted in the middle of a redirect
    redirect_i     = 1'b1;
    redirect_abs_i = 1'b1;
    target_i       = 32'h500;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_pc", pc_o, 32'h0);
    check_val("midrst_req", {31'h0, fetch_req_o}, 32'h0);
    redirect_i     = 1'b0;
    redirect_abs_i = 1'b0;
    target_i       = 32'h0;
    #2;
    rst_n = 1'b1;
    step();
    check_val("midrst_boot_pc", pc_o, 32'h0);
    check_val("midrst_boot_req", {31'h0, fetch_req_o}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
